// File: rtl/team_08_button_conditioner.sv
// Push-button conditioner: invert, 2-flop sync, debounce, registered press/release pulses.
// Latency: pin edge to btn_level is 2+DEBOUNCE_CYCLES edges, pulses one edge later; no backpressure.
// Optional autorepeat of btn_press while held when TEAM08_BTN_AUTOREPEAT_EN is defined.
module team_08_button_conditioner #(
    parameter int                 NUM_BTN         = 3,
    parameter int                 DEBOUNCE_CYCLES = 100000,
    parameter logic [NUM_BTN-1:0] INVERT_MASK     = 3'b100,
    parameter int                 REPEAT_DELAY    = 5000000,
    parameter int                 REPEAT_PERIOD   = 1000000
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] meta;
    logic [NUM_BTN-1:0] sync;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] stable_d;
    logic [NUM_BTN-1:0] accept;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] rep_fire;
    logic [CW-1:0]      cnt [NUM_BTN];

    // Inversion happens ahead of the synchroniser so every later stage sees active-high.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= btn_raw ^ INVERT_MASK;
            sync <= meta;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            accept[i] = (sync[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Any return of sync to the accepted level throws away the partial count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stable <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_level = stable;
    assign rise      = stable & ~stable_d;
    assign fall      = ~stable & stable_d;

`ifdef TEAM08_BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [NUM_BTN-1:0] rep_act;
    logic [RW-1:0]      rep_cnt [NUM_BTN];

    // A repeat is withheld on the edge that accepts the release, so it never trails btn_level.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_fire[i] = rep_act[i] && stable[i] && !accept[i] && (rep_cnt[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rep_act <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!stable[i]) begin
                    rep_act[i] <= 1'b0;
                    rep_cnt[i] <= '0;
                end else if (rise[i]) begin
                    rep_act[i] <= 1'b1;
                    rep_cnt[i] <= RW'(REPEAT_DELAY - 1);
                end else if (rep_act[i]) begin
                    if (rep_cnt[i] == '0) begin
                        rep_cnt[i] <= RW'(REPEAT_PERIOD - 1);
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] - 1'b1;
                    end
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stable_d    <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            any_press   <= 1'b0;
        end else begin
            stable_d    <= stable;
            btn_press   <= rise | rep_fire;
            btn_release <= fall;
            any_press   <= |(rise | rep_fire);
        end
    end

endmodule

// File: tb/tb_team_08_button_conditioner.sv
// Bench for team_08_button_conditioner: expected pulses are queued at stimulus time
// and compared against every press/release pulse the DUT emits.
module tb_team_08_button_conditioner;

    localparam int         NB  = 3;
    localparam int         DB  = 4;
    localparam int         RD  = 10;
    localparam int         RP  = 3;
    localparam logic [2:0] INV = 3'b100;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic       any_press;
    logic [2:0] pressed;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int n;
    int b;

    typedef struct {
        int         cyc;
        logic [2:0] press;
        logic [2:0] rel;
    } exp_t;

    exp_t q[$];
    exp_t e;

    team_08_button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(DB),
        .INVERT_MASK(INV),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] p, input logic [2:0] r);
        exp_t x;
        x.cyc   = c;
        x.press = p;
        x.rel   = r;
        q.push_back(x);
    endtask

    // Logical press pattern; the pin for inverted channels idles high.
    task automatic set_btn(input logic [2:0] p);
        pressed = p;
        btn_raw = p ^ INV;
    endtask

    task automatic at_edge(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int t);
        at_edge(t);
        @(negedge clk);
    endtask

    // Buttons m pressed cleanly after edge 'base' and released after edge base+hold.
    task automatic push_hold(input int base, input logic [2:0] m, input int hold);
        push(base + DB + 3, m, 3'b000);
`ifdef TEAM08_BTN_AUTOREPEAT_EN
        for (int t = base + DB + 3 + RD; t <= base + hold + DB + 1; t += RP) begin
            push(t, m, 3'b000);
        end
`endif
        push(base + hold + DB + 3, 3'b000, m);
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            check("press_release_overlap", int'(btn_press & btn_release), 0);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_pulse_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (btn_press != 3'b000 || btn_release != 3'b000) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", int'({btn_press, btn_release}), 0);
                end else begin
                    e = q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("btn_press", int'(btn_press), int'(e.press));
                    check("btn_release", int'(btn_release), int'(e.rel));
                    check("any_press", int'(any_press), int'(e.press != 3'b000));
                end
            end else begin
                check("any_press_idle", int'(any_press), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        set_btn(3'b000);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_level", int'(btn_level), 0);
        check("rst_press", int'(btn_press), 0);
        check("rst_release", int'(btn_release), 0);
        check("rst_any", int'(any_press), 0);
        @(posedge clk);
        #1 nrst = 1'b1;

        // Clean press and release on channel 0.
        n = cyc + 2;
        at_edge(n);
        set_btn(3'b001);
        push_hold(n, 3'b001, 20);
        sample(n + 5);
        check("clean_level_early", int'(btn_level), 0);
        sample(n + 6);
        check("clean_level", int'(btn_level), 1);
        at_edge(n + 20);
        set_btn(3'b000);
        sample(n + 25);
        check("clean_level_held", int'(btn_level), 1);
        sample(n + 26);
        check("clean_level_off", int'(btn_level), 0);
        n = n + 40;

        // Bounce on channel 1: two 3-cycle highs never qualify.
        at_edge(n);
        set_btn(3'b010);
        at_edge(n + 3);
        set_btn(3'b000);
        at_edge(n + 4);
        set_btn(3'b010);
        sample(n + 6);
        check("bounce_level_mid", int'(btn_level), 0);
        at_edge(n + 7);
        set_btn(3'b000);
        sample(n + 12);
        check("bounce_level_end", int'(btn_level), 0);
        n = n + 20;

        // Inverted channel 2: pin low for 10 cycles.
        at_edge(n);
        set_btn(3'b100);
        push_hold(n, 3'b100, 10);
        sample(n + 6);
        check("inv_level", int'(btn_level), 4);
        at_edge(n + 10);
        set_btn(3'b000);
        sample(n + 15);
        check("inv_level_held", int'(btn_level), 4);
        sample(n + 16);
        check("inv_level_off", int'(btn_level), 0);
        n = n + 30;

        // Reset while channel 1 is held and channel 0 is mid-qualification.
        at_edge(n);
        set_btn(3'b010);
        push(n + 7, 3'b010, 3'b000);
        sample(n + 6);
        check("pre_rst_level", int'(btn_level), 2);
        at_edge(n + 9);
        set_btn(3'b011);
        at_edge(n + 12);
        nrst = 1'b0;
        #1;
        check("async_rst_level", int'(btn_level), 0);
        check("async_rst_press", int'(btn_press), 0);
        check("async_rst_release", int'(btn_release), 0);
        check("async_rst_any", int'(any_press), 0);
        at_edge(n + 13);
        nrst = 1'b1;
        b = n + 13;
        push_hold(b, 3'b011, 12);
        sample(b + 5);
        check("post_rst_level_early", int'(btn_level), 0);
        sample(b + 6);
        check("post_rst_level", int'(btn_level), 3);
        at_edge(b + 12);
        set_btn(3'b000);
        n = b + 30;

        // Simultaneous edges on channels 0 and 1.
        at_edge(n);
        set_btn(3'b011);
        push_hold(n, 3'b011, 8);
        at_edge(n + 8);
        set_btn(3'b000);
        n = n + 25;

        // Long hold: autorepeat when enabled, single press otherwise.
        at_edge(n);
        set_btn(3'b001);
        push_hold(n, 3'b001, 30);
        at_edge(n + 30);
        set_btn(3'b000);
        n = n + 45;

        at_edge(n);
        check("queue_left", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
